// File: rtl/pisa_io_pkg.sv
// Shared definitions for the input window: register offsets, access-size
// encoding used by the memory controller, and debounce FSM states.
package pisa_io_pkg;

  localparam logic [31:0] INPUT_SW_OFS  = 32'h0;
  localparam logic [31:0] INPUT_BTN_OFS = 32'h4;
  localparam logic [31:0] INPUT_EVT_OFS = 32'h8;
  localparam logic [31:0] INPUT_CNT_OFS = 32'hC;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } access_size_e;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// One input channel: 2-flop synchronizer followed by a debounce FSM that
// accepts a new level after DEBOUNCE_CYCLES consecutive mismatching cycles.
module input_debouncer
  import pisa_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          synced;
  db_state_e     state;
  logic [CW-1:0] cnt;

  assign synced = sync[1];

  // The cycle that leaves STABLE is already the first mismatch, so cnt starts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      state <= DB_STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      case (state)
        DB_STABLE: begin
          if (synced != level) begin
            state <= DB_COUNTING;
            cnt   <= CW'(1);
          end
        end
        DB_COUNTING: begin
          if (synced == level) begin
            state <= DB_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            level <= synced;
            rise  <= synced;
            state <= DB_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= DB_STABLE;
      endcase
    end
  end

endmodule

// File: rtl/input_map.sv
// Memory-mapped switch/button input block: debounced levels, press-event
// latch with read-to-clear, press counter. Optional irq via INPUT_MAP_IRQ_EN.
module input_map
  import pisa_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_BTN         = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        sw,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [31:0]        input_address,
  input  logic [1:0]         input_size,
  input  logic               input_read_enable,
  output logic [31:0]        input_out,
  output logic               input_valid,
`ifdef INPUT_MAP_IRQ_EN
  output logic               input_error,
  output logic               irq
`else
  output logic               input_error
`endif
);

  logic [15:0]        sw_level;
  logic [15:0]        unused_sw_rise;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] evt;
  logic [NUM_BTN-1:0] evt_clr;
  logic [NUM_BTN-1:0] evt_next;
  logic [15:0]        press_cnt;

  for (genvar i = 0; i < 16; i++) begin : g_sw
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw[i]),
      .level (sw_level[i]),
      .rise  (unused_sw_rise[i])
    );
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[i]),
      .level (btn_level[i]),
      .rise  (btn_rise[i])
    );
  end

  logic [15:0]  btn16, evt16, rise16;
  access_size_e size;
  logic         misaligned, acc_err, rd_evt;
  logic [4:0]   shift;
  logic [31:0]  word, lane_mask, rd_data;

  assign size  = access_size_e'(input_size);
  assign shift = {input_address[1:0], 3'b000};

  always_comb begin
    btn16  = '0;
    evt16  = '0;
    rise16 = '0;
    btn16[NUM_BTN-1:0]  = btn_level;
    evt16[NUM_BTN-1:0]  = evt;
    rise16[NUM_BTN-1:0] = btn_rise;
  end

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SIZE_HALF: misaligned = input_address[0];
      SIZE_WORD: misaligned = |input_address[1:0];
      default:   misaligned = 1'b0;
    endcase
    acc_err = (size == SIZE_ILLEGAL) || misaligned || (|input_address[31:4]);
  end

  always_comb begin
    word = '0;
    case (input_address[3:2])
      INPUT_SW_OFS[3:2]:  word = {16'h0, sw_level};
      INPUT_BTN_OFS[3:2]: word = {16'h0, btn16};
      INPUT_EVT_OFS[3:2]: word = {16'h0, evt16};
      INPUT_CNT_OFS[3:2]: word = {16'h0, press_cnt};
      default:            word = '0;
    endcase
    case (size)
      SIZE_BYTE: lane_mask = 32'h0000_00FF << shift;
      SIZE_HALF: lane_mask = 32'h0000_FFFF << shift;
      default:   lane_mask = 32'hFFFF_FFFF;
    endcase
    rd_data = (word & lane_mask) >> shift;
  end

  // Only the bits actually returned are cleared; a same-cycle press still sets.
  assign rd_evt   = input_read_enable && !acc_err && (input_address[3:2] == INPUT_EVT_OFS[3:2]);
  assign evt_clr  = rd_evt ? lane_mask[NUM_BTN-1:0] : '0;
  assign evt_next = (evt & ~evt_clr) | btn_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt         <= '0;
      press_cnt   <= '0;
      input_out   <= '0;
      input_valid <= 1'b0;
      input_error <= 1'b0;
    end else begin
      evt         <= evt_next;
      press_cnt   <= press_cnt + 16'(popcount16(rise16));
      input_valid <= input_read_enable;
      input_error <= input_read_enable && acc_err;
      input_out   <= (input_read_enable && !acc_err) ? rd_data : '0;
    end
  end

`ifdef INPUT_MAP_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |evt_next;
  end
`endif

endmodule

// File: tb/tb_input_map.sv
// Directed bench for input_map with DEBOUNCE_CYCLES=4, NUM_BTN=5.
module tb_input_map;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   sw = '0;
  logic [NB-1:0] btn = '0;
  logic [31:0]   input_address = '0;
  logic [1:0]    input_size = 2'b10;
  logic          input_read_enable = 1'b0;
  logic [31:0]   input_out;
  logic          input_valid;
  logic          input_error;
`ifdef INPUT_MAP_IRQ_EN
  logic          irq;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  input_map #(.DEBOUNCE_CYCLES(4), .NUM_BTN(NB)) dut (
    .clk               (clk),
    .rst               (rst),
    .sw                (sw),
    .btn               (btn),
    .input_address     (input_address),
    .input_size        (input_size),
    .input_read_enable (input_read_enable),
    .input_out         (input_out),
    .input_valid       (input_valid),
`ifdef INPUT_MAP_IRQ_EN
    .input_error       (input_error),
    .irq               (irq)
`else
    .input_error       (input_error)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; strobe is sampled at the next posedge, result read at the following negedge.
  task automatic rd(input logic [31:0] a, input logic [1:0] sz,
                    output logic [31:0] d, output logic v, output logic e);
    input_address     = a;
    input_size        = sz;
    input_read_enable = 1'b1;
    @(negedge clk);
    input_read_enable = 1'b0;
    d = input_out;
    v = input_valid;
    e = input_error;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] exp);
    logic [31:0] d;
    logic v, e;
    rd(a, sz, d, v, e);
    check({tag, "_valid"}, {31'b0, v}, 32'd1);
    check({tag, "_err"}, {31'b0, e}, 32'd0);
    check(tag, d, exp);
  endtask

  task automatic errchk(input string tag, input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] d;
    logic v, e;
    rd(a, sz, d, v, e);
    check({tag, "_valid"}, {31'b0, v}, 32'd1);
    check({tag, "_err"}, {31'b0, e}, 32'd1);
    check({tag, "_out"}, d, 32'd0);
  endtask

  task automatic press(input logic [NB-1:0] m, input int hold);
    btn = m;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_out", input_out, 32'd0);
    check("rst_valid", {31'b0, input_valid}, 32'd0);
    check("rst_err", {31'b0, input_error}, 32'd0);
`ifdef INPUT_MAP_IRQ_EN
    check("rst_irq", {31'b0, irq}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    rdchk("rst_sw", 32'h0, 2'b10, 32'h0);
    @(negedge clk);
    check("idle_valid", {31'b0, input_valid}, 32'd0);
    check("idle_err", {31'b0, input_error}, 32'd0);

    // switches and lane selects
    sw = 16'h00A5;
    repeat (10) @(negedge clk);
    rdchk("sw_word", 32'h0, 2'b10, 32'h0000_00A5);
    sw = 16'h12A5;
    repeat (10) @(negedge clk);
    rdchk("sw_byte1", 32'h1, 2'b00, 32'h12);
    rdchk("sw_half0", 32'h0, 2'b01, 32'h12A5);
    rdchk("sw_half2", 32'h2, 2'b01, 32'h0);

    // glitch shorter than the debounce window is rejected
    press(5'b00001, 2);
    rdchk("glitch_btn", 32'h4, 2'b10, 32'h0);
    rdchk("glitch_evt", 32'h8, 2'b10, 32'h0);
    rdchk("glitch_cnt", 32'hC, 2'b10, 32'h0);

    // held press, read-to-clear
    btn = 5'b00100;
    repeat (8) @(negedge clk);
    rdchk("held_btn", 32'h4, 2'b10, 32'h4);
    btn = '0;
    repeat (10) @(negedge clk);
    rdchk("press_evt", 32'h8, 2'b10, 32'h4);
    rdchk("press_evt2", 32'h8, 2'b10, 32'h0);
    rdchk("press_cnt", 32'hC, 2'b10, 32'h1);

    // press accepted in the same cycle as the clearing read: set wins
    btn = 5'b01000;
    repeat (6) @(negedge clk);
    rdchk("race_evt1", 32'h8, 2'b10, 32'h0);
    rdchk("race_evt2", 32'h8, 2'b10, 32'h8);
    btn = '0;
    repeat (10) @(negedge clk);

    // simultaneous presses
    press(5'b10001, 8);
`ifdef INPUT_MAP_IRQ_EN
    check("irq_set", {31'b0, irq}, 32'd1);
`endif
    rdchk("multi_evt", 32'h8, 2'b10, 32'h11);
`ifdef INPUT_MAP_IRQ_EN
    check("irq_clr", {31'b0, irq}, 32'd0);
`endif
    rdchk("multi_cnt", 32'hC, 2'b10, 32'h4);

    // illegal accesses leave the latch alone; byte read clears only its lane
    press(5'b00010, 8);
    errchk("mis_word", 32'h2, 2'b10);
    errchk("size11", 32'h0, 2'b11);
    errchk("ofs10", 32'h10, 2'b10);
    errchk("mis_evt", 32'h9, 2'b10);
    errchk("mis_half", 32'h9, 2'b01);
    rdchk("evt_byte9", 32'h9, 2'b00, 32'h0);
`ifdef INPUT_MAP_IRQ_EN
    check("irq_hold", {31'b0, irq}, 32'd1);
`endif
    rdchk("evt_byte8", 32'h8, 2'b00, 32'h2);
`ifdef INPUT_MAP_IRQ_EN
    check("irq_clr2", {31'b0, irq}, 32'd0);
`endif
    rdchk("evt_after", 32'h8, 2'b10, 32'h0);
    rdchk("cnt_5", 32'hC, 2'b10, 32'h5);

    // counter wrap
    force dut.press_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.press_cnt;
    rdchk("cnt_ffff", 32'hC, 2'b10, 32'hFFFF);
    press(5'b00100, 8);
    rdchk("cnt_wrap", 32'hC, 2'b10, 32'h0);
    rdchk("wrap_evt", 32'h8, 2'b10, 32'h4);

    // reset mid-debounce with a strobe during reset
    sw = 16'hFFFF;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    input_address = 32'h0;
    input_size = 2'b10;
    input_read_enable = 1'b1;
    @(negedge clk);
    input_read_enable = 1'b0;
    check("rst_strobe_valid", {31'b0, input_valid}, 32'd0);
    check("rst_strobe_out", input_out, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rdchk("rst_pending", 32'h0, 2'b10, 32'h0);
    repeat (10) @(negedge clk);
    rdchk("rst_reaccept", 32'h0, 2'b10, 32'hFFFF);
    rdchk("rst_cnt", 32'hC, 2'b10, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_map.md
INPUT_MAP -- requirements
Module: input_map

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, cycles a synchronized input must hold a new level before acceptance (minimum 2).
REQ-002 Parameter NUM_BTN, default 5, number of push-button inputs (1..16).
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sw  input  16  raw asynchronous slide-switch levels.
REQ-006 btn  input  NUM_BTN  raw asynchronous push-button levels, 1 = pressed.
REQ-007 input_address  input  32  byte address from memory controller, offset within input window.
REQ-008 input_size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 input_read_enable  input  1  one-cycle read strobe.
REQ-010 input_out  output  32  read data, valid the cycle after strobe.
REQ-011 input_valid  output  1  pulses one cycle with input_out.
REQ-012 input_error  output  1  pulses with input_valid on illegal access.

Function
REQ-013 Every sw/btn bit SHALL pass a 2-flop synchronizer before any other use.
REQ-014 Each channel SHALL run a debounce FSM: STABLE (synced == accepted) -> COUNTING on mismatch; COUNTING returns to STABLE without change if synced reverts; accepts new level after DEBOUNCE_CYCLES consecutive mismatch cycles, then STABLE.
REQ-015 Register map (word offsets): 0x0 debounced sw in [15:0]; 0x4 debounced btn in [NUM_BTN-1:0]; 0x8 press-event latch; 0xC press counter [15:0]; unused bits read 0.
REQ-016 Accepted 0->1 btn transition SHALL set its event bit and increment the counter by 1 per channel (modulo 2^16, wraps 0xFFFF->0x0000); simultaneous presses add the number of presses.
REQ-017 Read of 0x8 SHALL return latch then clear read bits; a press in the same cycle SHALL remain set (set wins).
REQ-018 Read latency exactly 1 cycle; back-to-back strobes each answered in order.
REQ-019 Byte/halfword reads return selected lane zero-extended into input_out[7:0]/[15:0]; byte read of 0x8 clears only the returned bits.
REQ-020 Misaligned access, input_size 11, or offset >= 0x10 SHALL assert input_error, input_out = 0, no side effects.
REQ-021 input_valid/input_error SHALL be 0 when no strobe preceded.

Reset
REQ-022 rst SHALL clear synchronizers, accepted levels, counters, event latch, counter register, input_out, input_valid, input_error to 0; FSMs to STABLE.
REQ-023 rst asserted mid-debounce discards the pending count; strobe during rst is dropped.

Configuration
REQ-024 Macro INPUT_MAP_IRQ_EN SHALL add output irq (1 bit), registered, high while any event-latch bit set; falls the cycle after the clearing read.
REQ-025 Without INPUT_MAP_IRQ_EN the irq port and logic SHALL not exist; all other behaviour identical.

Structure
REQ-026 Package pisa_io_pkg SHALL hold register offsets (INPUT_SW_OFS, INPUT_BTN_OFS, INPUT_EVT_OFS, INPUT_CNT_OFS) and the access-size enum shared with the memory controller.
REQ-027 Per-channel synchronizer plus debounce FSM SHALL be sub-module input_debouncer, instantiated per sw/btn bit, outputting level and rise pulse.

Verification
REQ-028 DEBOUNCE_CYCLES=4: sw=0x00A5 held 10 cycles, read 0x0 word -> input_out=0x000000A5, input_valid one cycle after strobe.
REQ-029 btn[0] glitch high 2 cycles then low -> 0x4 reads 0, 0x8 reads 0, counter 0.
REQ-030 btn[2] press held 8 cycles -> 0x8 reads 0x4 then 0x0 on second read; 0xC reads 1.
REQ-031 Press accepted same cycle as 0x8 read -> first read 0, next read shows bit set.
REQ-032 Word read at 0x2 and size 11 at 0x0 -> input_error=1, input_out=0; read at 0x10 -> error; latch unchanged.
REQ-033 Counter preloaded to 0xFFFF via 65535 presses (or forced) plus one press -> 0xC reads 0x0000; with INPUT_MAP_IRQ_EN irq tracks latch per REQ-024.
